// File: rtl/commit_pkg.sv
// Shared types for the commit-stream checker: record layout,
// field-mask bit positions and checker states.
package commit_pkg;

   localparam int CMT_XLEN = 64;

   localparam int FLD_PC      = 0;
   localparam int FLD_INSTR   = 1;
   localparam int FLD_RD_ADDR = 2;
   localparam int FLD_RD_DATA = 3;
   localparam int FLD_MEM_WE  = 4;
   localparam int FLD_MEM     = 5;
   localparam int FLD_TRAP    = 6;
   localparam int FLD_PRIV    = 7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_RUN      = 2'b01,
      ST_MISMATCH = 2'b10,
      ST_ERROR    = 2'b11
   } chk_state_e;

   typedef struct packed {
      logic [CMT_XLEN-1:0] pc;
      logic [31:0]         instr;
      logic [4:0]          rd_addr;
      logic [CMT_XLEN-1:0] rd_data;
      logic                mem_we;
      logic [CMT_XLEN-1:0] mem_addr;
      logic [CMT_XLEN-1:0] mem_wdata;
      logic                trap;
      logic [1:0]          priv;
   } commit_rec_t;

   // rd_data is don't-care for x0 writes; memory payload only when both store
   function automatic logic [7:0] cmp_rec(input commit_rec_t d,
                                          input commit_rec_t r);
      logic [7:0] m;
      m = '0;
      m[FLD_PC]      = d.pc != r.pc;
      m[FLD_INSTR]   = d.instr != r.instr;
      m[FLD_RD_ADDR] = d.rd_addr != r.rd_addr;
      m[FLD_RD_DATA] = (d.rd_addr != 5'd0) && (d.rd_data != r.rd_data);
      m[FLD_MEM_WE]  = d.mem_we != r.mem_we;
      m[FLD_MEM]     = d.mem_we && r.mem_we &&
                       ((d.mem_addr != r.mem_addr) ||
                        (d.mem_wdata != r.mem_wdata));
      m[FLD_TRAP]    = d.trap != r.trap;
      m[FLD_PRIV]    = d.priv != r.priv;
      return m;
   endfunction

endpackage

// File: rtl/commit_if.sv
// Retirement record bundle shared by the DUT and reference drivers;
// mon is the sample-only view used by consumers.
interface commit_if #(
   parameter int XLEN = 64
);
   logic            valid;
   logic [XLEN-1:0] pc;
   logic [31:0]     instr;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_data;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic            trap;
   logic [1:0]      priv;

   modport mon (
      input valid, pc, instr, rd_addr, rd_data,
            mem_we, mem_addr, mem_wdata, trap, priv
   );
endinterface

// File: rtl/commit_fifo.sv
// Synchronous FIFO of commit records; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module commit_fifo
   import commit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   push,
   input  logic                   pop,
   input  commit_rec_t            din,
   output commit_rec_t            dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   commit_rec_t   mem [DEPTH];
   logic [AW:0]   wp;
   logic [AW:0]   rp;
   logic          wr_en;
   logic          rd_en;

   assign empty = wp == rp;
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign count = wp - rp;
   assign dout  = mem[rp[AW-1:0]];

   // a full FIFO still accepts a write when the head leaves on the same edge
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_en) wp <= wp + 1'b1;
         if (rd_en) rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wp[AW-1:0]] <= din;
   end

endmodule

// File: rtl/commit_stream_checker.sv
// Lock-step comparison of DUT and reference retirement streams with
// skew buffering, first-divergence capture and stall/overflow detection.
module commit_stream_checker
   import commit_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            rst,
   commit_if.mon           dut_cmt,
   commit_if.mon           ref_cmt,
   input  logic            cmp_en,
   input  logic            clr,
   output logic            mismatch,
   output logic [7:0]      mismatch_field,
   output logic [31:0]     mismatch_idx,
   output logic [XLEN-1:0] mismatch_pc,
   output logic [31:0]     match_cnt,
   output logic            overflow,
   output logic            timeout,
   output logic            halt_req,
   output logic [1:0]      state
);
   localparam int AW = $clog2(DEPTH);

   chk_state_e  st;
   chk_state_e  st_nx;
   commit_rec_t dut_rec;
   commit_rec_t ref_rec;
   commit_rec_t dut_head;
   commit_rec_t ref_head;
   logic        dut_full;
   logic        ref_full;
   logic        dut_empty;
   logic        ref_empty;
   logic [AW:0] dut_cnt;
   logic [AW:0] ref_cnt;
   logic [31:0] stall_cnt;
   logic [7:0]  diff;
   logic        run_act;
   logic        flush;
   logic        dut_push;
   logic        ref_push;
   logic        pop;
   logic        mism;
   logic        ovf;
   logic        stalling;
   logic        tmo;

   always_comb begin
      dut_rec           = '0;
      dut_rec.pc        = CMT_XLEN'(dut_cmt.pc);
      dut_rec.instr     = dut_cmt.instr;
      dut_rec.rd_addr   = dut_cmt.rd_addr;
      dut_rec.rd_data   = CMT_XLEN'(dut_cmt.rd_data);
      dut_rec.mem_we    = dut_cmt.mem_we;
      dut_rec.mem_addr  = CMT_XLEN'(dut_cmt.mem_addr);
      dut_rec.mem_wdata = CMT_XLEN'(dut_cmt.mem_wdata);
      dut_rec.trap      = dut_cmt.trap;
      dut_rec.priv      = dut_cmt.priv;
      ref_rec           = '0;
      ref_rec.pc        = CMT_XLEN'(ref_cmt.pc);
      ref_rec.instr     = ref_cmt.instr;
      ref_rec.rd_addr   = ref_cmt.rd_addr;
      ref_rec.rd_data   = CMT_XLEN'(ref_cmt.rd_data);
      ref_rec.mem_we    = ref_cmt.mem_we;
      ref_rec.mem_addr  = CMT_XLEN'(ref_cmt.mem_addr);
      ref_rec.mem_wdata = CMT_XLEN'(ref_cmt.mem_wdata);
      ref_rec.trap      = ref_cmt.trap;
      ref_rec.priv      = ref_cmt.priv;
   end

   assign run_act  = (st == ST_RUN) && cmp_en;
   assign flush    = (st == ST_RUN) && !cmp_en;
   assign dut_push = run_act && dut_cmt.valid;
   assign ref_push = run_act && ref_cmt.valid;
   assign pop      = run_act && !dut_empty && !ref_empty;
   assign diff     = cmp_rec(dut_head, ref_head);
   assign mism     = pop && (diff != 8'd0);
   assign ovf      = (dut_push && dut_full && !pop) ||
                     (ref_push && ref_full && !pop);
   assign stalling = run_act && !pop &&
                     ((dut_cnt != '0) != (ref_cnt != '0));
   assign tmo      = stalling && (stall_cnt == 32'(TIMEOUT - 1));
   assign state    = st;
   assign halt_req = (st == ST_MISMATCH) || (st == ST_ERROR);

   commit_fifo #(.DEPTH(DEPTH)) u_dut_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr || flush),
      .push  (dut_push),
      .pop   (pop),
      .din   (dut_rec),
      .dout  (dut_head),
      .full  (dut_full),
      .empty (dut_empty),
      .count (dut_cnt)
   );

   commit_fifo #(.DEPTH(DEPTH)) u_ref_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr || flush),
      .push  (ref_push),
      .pop   (pop),
      .din   (ref_rec),
      .dout  (ref_head),
      .full  (ref_full),
      .empty (ref_empty),
      .count (ref_cnt)
   );

   always_comb begin
      st_nx = st;
      case (st)
         ST_IDLE: if (cmp_en) st_nx = ST_RUN;
         ST_RUN: begin
            if (!cmp_en)          st_nx = ST_IDLE;
            else if (ovf || tmo)  st_nx = ST_ERROR;
            else if (mism)        st_nx = ST_MISMATCH;
         end
         default: st_nx = st;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         st             <= ST_IDLE;
         mismatch       <= 1'b0;
         mismatch_field <= '0;
         mismatch_idx   <= '0;
         mismatch_pc    <= '0;
         match_cnt      <= '0;
         overflow       <= 1'b0;
         timeout        <= 1'b0;
         stall_cnt      <= '0;
      end else begin
         st        <= st_nx;
         stall_cnt <= stalling ? stall_cnt + 1'b1 : 32'd0;
         if (mism) begin
            mismatch       <= 1'b1;
            mismatch_field <= diff;
            mismatch_idx   <= match_cnt;
            mismatch_pc    <= XLEN'(dut_head.pc);
         end else if (pop && (match_cnt != 32'hFFFF_FFFF)) begin
            match_cnt <= match_cnt + 1'b1;
         end
         if (ovf) overflow <= 1'b1;
         if (tmo) timeout  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_commit_stream_checker.sv
// Directed checks of the commit-stream checker: matching, divergence,
// masked fields, skew with stall timeout, overflow, reset and clear.
module tb_commit_stream_checker;
   import commit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmp_en;
   logic        clr;
   logic        mismatch;
   logic [7:0]  mismatch_field;
   logic [31:0] mismatch_idx;
   logic [63:0] mismatch_pc;
   logic [31:0] match_cnt;
   logic        overflow;
   logic        timeout;
   logic        halt_req;
   logic [1:0]  state;

   int n_chk  = 0;
   int n_fail = 0;

   commit_if #(.XLEN(64)) dut_if ();
   commit_if #(.XLEN(64)) ref_if ();

   commit_stream_checker #(
      .DEPTH   (8),
      .XLEN    (64),
      .TIMEOUT (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .dut_cmt        (dut_if),
      .ref_cmt        (ref_if),
      .cmp_en         (cmp_en),
      .clr            (clr),
      .mismatch       (mismatch),
      .mismatch_field (mismatch_field),
      .mismatch_idx   (mismatch_idx),
      .mismatch_pc    (mismatch_pc),
      .match_cnt      (match_cnt),
      .overflow       (overflow),
      .timeout        (timeout),
      .halt_req       (halt_req),
      .state          (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic commit_rec_t mk(input logic [63:0] pc);
      commit_rec_t r;
      r         = '0;
      r.pc      = pc;
      r.instr   = 32'h0000_0013 ^ pc[31:0];
      r.rd_addr = 5'd1;
      r.rd_data = pc + 64'h100;
      r.priv    = 2'b11;
      return r;
   endfunction

   task automatic drive(input logic dv, input commit_rec_t d,
                        input logic rv, input commit_rec_t r);
      dut_if.valid     = dv;
      dut_if.pc        = d.pc;
      dut_if.instr     = d.instr;
      dut_if.rd_addr   = d.rd_addr;
      dut_if.rd_data   = d.rd_data;
      dut_if.mem_we    = d.mem_we;
      dut_if.mem_addr  = d.mem_addr;
      dut_if.mem_wdata = d.mem_wdata;
      dut_if.trap      = d.trap;
      dut_if.priv      = d.priv;
      ref_if.valid     = rv;
      ref_if.pc        = r.pc;
      ref_if.instr     = r.instr;
      ref_if.rd_addr   = r.rd_addr;
      ref_if.rd_data   = r.rd_data;
      ref_if.mem_we    = r.mem_we;
      ref_if.mem_addr  = r.mem_addr;
      ref_if.mem_wdata = r.mem_wdata;
      ref_if.trap      = r.trap;
      ref_if.priv      = r.priv;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, '0);
   endtask

   task automatic enter_run();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_state"}, state, 2'b00);
      check({tag, "_mism"}, mismatch, 1'b0);
      check({tag, "_field"}, mismatch_field, 8'h00);
      check({tag, "_idx"}, mismatch_idx, 32'd0);
      check({tag, "_pc"}, mismatch_pc, 64'd0);
      check({tag, "_mcnt"}, match_cnt, 32'd0);
      check({tag, "_ovf"}, overflow, 1'b0);
      check({tag, "_tmo"}, timeout, 1'b0);
      check({tag, "_halt"}, halt_req, 1'b0);
      check({tag, "_dcnt"}, dut.u_dut_fifo.count, 4'd0);
      check({tag, "_rcnt"}, dut.u_ref_fifo.count, 4'd0);
   endtask

   initial begin
      commit_rec_t a;
      commit_rec_t b;
      rst    = 1'b1;
      clr    = 1'b0;
      cmp_en = 1'b0;
      idle();
      tick();
      tick();
      rst = 1'b0;
      check_cleared("reset");

      // five identical commits
      cmp_en = 1'b1;
      tick();
      check("run_entry", state, 2'b01);
      for (int i = 0; i < 5; i++) begin
         a = mk(64'h8000_0000 + 64'(4 * i));
         drive(1'b1, a, 1'b1, a);
         tick();
      end
      idle();
      tick();
      tick();
      check("match5_cnt", match_cnt, 32'd5);
      check("match5_mism", mismatch, 1'b0);
      check("match5_state", state, 2'b01);

      // rd_data divergence on the third commit
      enter_run();
      check("clr_mcnt", match_cnt, 32'd0);
      for (int i = 0; i < 4; i++) begin
         a = mk(64'h8000_0000 + 64'(4 * i));
         b = a;
         if (i == 2) begin
            a.rd_addr = 5'd5;
            b.rd_addr = 5'd5;
            a.rd_data = 64'h10;
            b.rd_data = 64'h11;
         end
         drive(1'b1, a, 1'b1, b);
         tick();
      end
      idle();
      tick();
      tick();
      check("mm_flag", mismatch, 1'b1);
      check("mm_field", mismatch_field, 8'h08);
      check("mm_idx", mismatch_idx, 32'd2);
      check("mm_pc", mismatch_pc, 64'h8000_0008);
      check("mm_mcnt", match_cnt, 32'd2);
      check("mm_state", state, 2'b10);
      check("mm_halt", halt_req, 1'b1);

      // masked fields: x0 rd_data and non-store mem_addr
      enter_run();
      a = mk(64'h100);
      b = a;
      a.rd_addr = 5'd0;
      b.rd_addr = 5'd0;
      a.rd_data = 64'hAA;
      b.rd_data = 64'hBB;
      drive(1'b1, a, 1'b1, b);
      tick();
      a = mk(64'h104);
      b = a;
      a.mem_addr = 64'h2000;
      b.mem_addr = 64'h3000;
      drive(1'b1, a, 1'b1, b);
      tick();
      idle();
      tick();
      tick();
      check("mask_mcnt", match_cnt, 32'd2);
      check("mask_mism", mismatch, 1'b0);

      // REF lags by three cycles, then DUT-only stall
      enter_run();
      for (int t = 0; t < 9; t++) begin
         drive(t < 6, mk(64'h1000 + 64'(4 * t)),
               t >= 3, mk(64'h1000 + 64'(4 * (t - 3))));
         tick();
      end
      idle();
      tick();
      tick();
      check("skew_mcnt", match_cnt, 32'd6);
      check("skew_mism", mismatch, 1'b0);
      drive(1'b1, mk(64'h2000), 1'b0, '0);
      tick();
      idle();
      for (int i = 0; i < 15; i++) tick();
      check("tmo_early", timeout, 1'b0);
      check("tmo_early_st", state, 2'b01);
      tick();
      check("tmo_flag", timeout, 1'b1);
      check("tmo_state", state, 2'b11);
      check("tmo_halt", halt_req, 1'b1);

      // overflow on the ninth DUT push
      enter_run();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, mk(64'h3000 + 64'(4 * i)), 1'b0, '0);
         tick();
      end
      check("ovf_pre", overflow, 1'b0);
      check("ovf_pre_cnt", dut.u_dut_fifo.count, 4'd8);
      drive(1'b1, mk(64'h3020), 1'b0, '0);
      tick();
      idle();
      check("ovf_flag", overflow, 1'b1);
      check("ovf_state", state, 2'b11);
      check("ovf_cnt", dut.u_dut_fifo.count, 4'd8);

      // mid-run rst, then mid-run clr, with four entries buffered
      for (int k = 0; k < 2; k++) begin
         enter_run();
         a = mk(64'h4000);
         drive(1'b1, a, 1'b1, a);
         tick();
         a = mk(64'h4004);
         drive(1'b1, a, 1'b1, a);
         tick();
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(64'h4008 + 64'(4 * i)), 1'b0, '0);
            tick();
         end
         idle();
         check("buf_cnt", dut.u_dut_fifo.count, 4'd4);
         check("buf_mcnt", match_cnt, 32'd2);
         if (k == 0) rst = 1'b1;
         else        clr = 1'b1;
         tick();
         rst = 1'b0;
         clr = 1'b0;
         check_cleared(k == 0 ? "midrst" : "midclr");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
